// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and FSM state type for the BCD/XS3 codec
package bcd_pkg;

    localparam logic MODE_BCD2XS3 = 1'b0;
    localparam logic MODE_XS32BCD = 1'b1;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/xs3_digit_conv.sv
// rtl/xs3_digit_conv.sv - single-digit combinational BCD<->XS3 converter
module xs3_digit_conv
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    input  logic       mode,
    output logic [3:0] q,
    output logic       err
);

    // Out-of-range digits yield a zero result so no X ever reaches the output word
    always_comb begin
        q   = 4'h0;
        err = 1'b0;
        if (mode == MODE_BCD2XS3) begin
            if (d <= BCD_MAX) begin
                q = d + XS3_OFFSET;
            end else begin
                err = 1'b1;
            end
        end else begin
            if ((d >= XS3_MIN) && (d <= XS3_MAX)) begin
                q = d - XS3_OFFSET;
            end else begin
                err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_xs3_codec_seq.sv
// rtl/bcd_xs3_codec_seq.sv - multi-digit serial BCD/XS3 converter with valid/ready ports
module bcd_xs3_codec_seq
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [4*NDIGITS-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NDIGITS-1:0]   out_data,
    output logic [NDIGITS-1:0]     out_err,
    output logic                   busy
);

    // A one-digit word still needs a one-bit index register
    localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

    state_t                 state;
    logic [IDXW-1:0]        idx;
    logic [4*NDIGITS-1:0]   word;
    logic                   mode;
    logic [3:0]             cur_digit;
    logic [3:0]             conv_q;
    logic                   conv_err;

    assign in_ready = (state == IDLE);

    // Select the digit currently being converted from the captured word
    always_comb begin
        cur_digit = 4'h0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IDXW'(i)) begin
                cur_digit = word[4*i +: 4];
            end
        end
    end

    xs3_digit_conv u_conv (
        .d    (cur_digit),
        .mode (mode),
        .q    (conv_q),
        .err  (conv_err)
    );

    // Control FSM: capture in IDLE, one digit per cycle in CONV, hold result in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            word      <= '0;
            mode      <= MODE_BCD2XS3;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word  <= in_data;
                        mode  <= in_mode;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (idx == IDXW'(i)) begin
                            out_data[4*i +: 4] <= conv_q;
                            out_err[i]         <= conv_err;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_xs3_codec_seq.sv
// tb/tb_bcd_xs3_codec_seq.sv - scoreboard bench for the serial BCD/XS3 codec
module tb_bcd_xs3_codec_seq;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [3:0]  out_err;
    logic        busy;

    bcd_xs3_codec_seq #(.NDIGITS(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  e;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_edge = 0;
    bit   rec_acc = 0;
    bit   prev_valid = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [19:0] model(input logic m, input logic [15:0] d);
        logic [15:0] q;
        logic [3:0]  e;
        logic [3:0]  x;
        q = '0;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            x = d[4*i +: 4];
            if (!m) begin
                if (x < 4'd10) q[4*i +: 4] = x + 4'd3;
                else e[i] = 1'b1;
            end else begin
                if (x >= 4'd3 && x <= 4'd12) q[4*i +: 4] = x - 4'd3;
                else e[i] = 1'b1;
            end
        end
        return {e, q};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: accept timestamps, latency, and scoreboard pops on output handshakes
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 0;
        end else begin
            if (in_valid && in_ready) begin
                acc_edge = cyc + 1;
                if (rec_acc) acc_q.push_back(cyc + 1);
            end
            if (out_valid && !prev_valid) check("latency", cyc - acc_edge, ND);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_err", out_err, e.e);
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic send(input logic m, input logic [15:0] d, input logic [15:0] ed,
                        input logic [3:0] ee, input bit push);
        int n = 0;
        in_mode  = m;
        in_data  = d;
        in_valid = 1'b1;
        if (push) exp_q.push_back('{ed, ee});
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] r;
        logic [15:0] rd;
        logic        rm;
        int          n;

        // Reset values
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_err", out_err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Mode 0 nominal, out_valid lasts one cycle with out_ready high
        send(1'b0, 16'h1234, 16'h4567, 4'b0000, 1);
        drain();
        check("valid_one_cycle", out_valid, 0);

        // Mode 1 nominal
        send(1'b1, 16'h3C3C, 16'h0909, 4'b0000, 1);
        send(1'b1, 16'h4567, 16'h1234, 4'b0000, 1);
        drain();

        // Error digits
        send(1'b0, 16'h9A0F, 16'hC030, 4'b0101, 1);
        send(1'b1, 16'h02DF, 16'h0000, 4'b1111, 1);
        drain();

        // Random words against the model
        for (int i = 0; i < 6; i++) begin
            rd = 16'($urandom);
            rm = 1'($urandom_range(0, 1));
            r  = model(rm, rd);
            send(rm, rd, r[15:0], r[19:16], 1);
        end
        drain();

        // Backpressure in DONE
        out_ready = 1'b0;
        send(1'b0, 16'h1234, 16'h4567, 4'b0000, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                in_valid = 1'b1;
                in_data  = 16'h5555;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 16'h4567);
            check("bp_err", out_err, 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_hold", out_valid, 1);
        @(posedge clk);
        #1;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_busy", busy, 0);

        // Asynchronous reset after two CONV cycles
        send(1'b0, 16'h9999, 16'h0, 4'h0, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_err", out_err, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(1'b0, 16'h0000, 16'h3333, 4'b0000, 1);
        drain();

        // Back-to-back with in_valid held high
        rec_acc  = 1;
        in_mode  = 1'b0;
        in_data  = 16'h0001;
        in_valid = 1'b1;
        exp_q.push_back('{16'h3334, 4'b0000});
        n = 0;
        while (acc_q.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_data = 16'h0002;
        exp_q.push_back('{16'h3335, 4'b0000});
        n = 0;
        while (acc_q.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rec_acc  = 0;
        if (acc_q.size() >= 2) check("b2b_gap", acc_q[1] - acc_q[0], ND + 2);
        else check("b2b_accepts", acc_q.size(), 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
